key_debounce: RTL

- Push-button input reader for the board's mechanical keys; the input-side companion to the LED output driver.
- Synchronises a raw, bouncy key pin to clk (25 MHz) and filters it with a stability counter.
- Produces a clean debounced level plus single-cycle press/release event pulses for downstream control logic.
- One instance per key; sits between the top-level key pin and user logic.

---
 rtl/key_debounce.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/key_debounce.sv
// Mechanical key reader: 2-FF synchroniser, stability-counter debounce FSM, and registered press/release pulses.
// Optional long-press detection is compiled in with `define KEY_LONG_PRESS_EN; otherwise key_long is tied to 0.
module key_debounce #(
  parameter int DB_CNT         = 500000,
  parameter int CNT_W          = 25,
  parameter int KEY_ACTIVE_LOW = 1,
  parameter int LONG_CNT       = 25000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic key_state,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_DB   = 2'd1,
    PRESSED    = 2'd2,
    RELEASE_DB = 2'd3
  } state_e;

  localparam logic             KP_INV  = (KEY_ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CNT - 1);

  // Out-of-range settings would let the counter wrap or never terminate.
  if (DB_CNT < 2 || longint'(DB_CNT) > ((longint'(1) << CNT_W) - 1) ||
      LONG_CNT < 1 || longint'(LONG_CNT) > ((longint'(1) << CNT_W) - 1)) begin : g_bad_cfg
    $error("key_debounce: DB_CNT/LONG_CNT out of range for CNT_W");
  end

  logic             sync1_q, sync2_q;
  logic             kp;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             key_state_q, key_state_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

  assign kp = key_in ^ KP_INV;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    key_state_d = key_state_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (sync2_q) begin
          state_d = PRESS_DB;
          cnt_d   = CNT_ONE;
        end
      end
      PRESS_DB: begin
        if (!sync2_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d     = PRESSED;
          cnt_d       = '0;
          key_state_d = 1'b1;
          press_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!sync2_q) begin
          state_d = RELEASE_DB;
          cnt_d   = CNT_ONE;
        end
      end
      RELEASE_DB: begin
        // A bounce back to pressed is silent: key_state never dropped.
        if (sync2_q) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d     = IDLE;
          cnt_d       = '0;
          key_state_d = 1'b0;
          release_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef KEY_LONG_PRESS_EN
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);
  localparam logic [CNT_W-1:0] LONG_MAX  = CNT_W'(LONG_CNT);

  logic [CNT_W-1:0] hold_q, hold_d;
  logic             long_q, long_d;

  // Hold count survives RELEASE_DB bounces and saturates so key_long fires once per press.
  always_comb begin
    hold_d = hold_q;
    long_d = 1'b0;
    if (state_q == PRESSED) begin
      if (sync2_q) begin
        if (hold_q == LONG_LAST) begin
          hold_d = LONG_MAX;
          long_d = 1'b1;
        end else if (hold_q < LONG_LAST) begin
          hold_d = hold_q + CNT_ONE;
        end
      end
    end else if (state_q != RELEASE_DB) begin
      hold_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  assign key_long = long_q;
`else
  assign key_long = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      key_state_q <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
    end else begin
      sync1_q     <= kp;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      key_state_q <= key_state_d;
      press_q     <= press_d;
      release_q   <= release_d;
    end
  end

  assign key_state   = key_state_q;
  assign key_press   = press_q;
  assign key_release = release_q;

endmodule
